// File: rtl/rf_access_ctrl_if.sv
// Command/response handshake plus register-file bus between the execute unit,
// the access controller and the 16 x 4-bit register file.
interface rf_access_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;
  logic [3:0] rf_addr;
  logic [3:0] rf_data_in;
  logic       rf_write_enable;
  logic       rf_select;
  logic [3:0] rf_data_out;

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready, rf_data_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err,
           rf_addr, rf_data_in, rf_write_enable, rf_select
  );

  modport master (
    output cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready, rf_data_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err,
           rf_addr, rf_data_in, rf_write_enable, rf_select
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// Expands one register-level command into single-port register file accesses.
// Optional write read-back check: define RF_WRITE_VERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// RA0    | first read address (reg, or even reg of a pair)
// RA1    | odd read address of a pair, capture even nibble
// RC1    | capture cycle for the last read
// WA0    | first write (reg, or even reg of a pair)
// WA1    | odd write of a pair
// VA     | read-back address after a write (verify build only)
// VC     | read-back capture and compare (verify build only)
// RESP   | response held until rsp_ready
module rf_access_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int RD_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  rf_access_ctrl_if.slave   bus
);

  if (NUM_REGS != 16 || RD_LAT != 1) begin : g_param_check
    $error("rf_access_ctrl supports only NUM_REGS=16 and RD_LAT=1");
  end

  localparam logic [2:0] OP_RD  = 3'd0;
  localparam logic [2:0] OP_WR  = 3'd1;
  localparam logic [2:0] OP_RDP = 3'd2;
  localparam logic [2:0] OP_WRP = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;
  localparam logic [2:0] OP_XCH = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_RA0, S_RA1, S_RC1, S_WA0, S_WA1, S_RESP
`ifdef RF_WRITE_VERIFY_EN
    , S_VA, S_VC
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [3:0] reg_q;
  logic [7:0] data_q;
  logic [3:0] even_q;
  logic [3:0] cap_q;

  logic       accept;
  logic [3:0] inc_val;
  logic [3:0] even_addr;
  logic [3:0] odd_addr;
  logic [3:0] wr0_addr;
  logic [3:0] wr0_nib;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign accept        = bus.cmd_valid && (state == S_IDLE);

  assign inc_val   = cap_q + 4'h1;
  assign even_addr = {reg_q[3:1], 1'b0};
  assign odd_addr  = {reg_q[3:1], 1'b1};
  assign wr0_addr  = (op_q == OP_WRP) ? even_addr : reg_q;
  assign wr0_nib   = (op_q == OP_WRP) ? data_q[7:4] :
                     (op_q == OP_INC) ? inc_val : data_q[3:0];

`ifdef RF_WRITE_VERIFY_EN
  logic       err_q;
  logic       wsel_q;
  logic [3:0] vfy_nib;

  assign vfy_nib     = wsel_q ? data_q[3:0] : wr0_nib;
  assign bus.rsp_err = (state == S_RESP) && err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      wsel_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q  <= 1'b0;
        wsel_q <= 1'b0;
      end
      if (state == S_WA1) wsel_q <= 1'b1;
      if (state == S_VC && bus.rf_data_out != vfy_nib) err_q <= 1'b1;
    end
  end
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= 3'd0;
      reg_q  <= 4'd0;
      data_q <= 8'd0;
      even_q <= 4'd0;
      cap_q  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= bus.cmd_op;
        reg_q  <= bus.cmd_reg;
        data_q <= bus.cmd_data;
      end
      if (state == S_RA1) even_q <= bus.rf_data_out;
      if (state == S_RC1) cap_q  <= bus.rf_data_out;
    end
  end

  always_comb begin
    state_nxt           = state;
    bus.rf_addr         = 4'd0;
    bus.rf_data_in      = 4'd0;
    bus.rf_write_enable = 1'b0;
    bus.rf_select       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_RD, OP_RDP, OP_INC, OP_XCH: state_nxt = S_RA0;
            OP_WR, OP_WRP:                 state_nxt = S_WA0;
            default:                       state_nxt = S_RESP;
          endcase
        end
      end
      S_RA0: begin
        bus.rf_select = 1'b1;
        bus.rf_addr   = (op_q == OP_RDP) ? even_addr : reg_q;
        state_nxt     = (op_q == OP_RDP) ? S_RA1 : S_RC1;
      end
      S_RA1: begin
        bus.rf_select = 1'b1;
        bus.rf_addr   = odd_addr;
        state_nxt     = S_RC1;
      end
      S_RC1: begin
        bus.rf_select = 1'b1;
        state_nxt     = (op_q == OP_INC || op_q == OP_XCH) ? S_WA0 : S_RESP;
      end
      S_WA0: begin
        bus.rf_write_enable = 1'b1;
        bus.rf_addr         = wr0_addr;
        bus.rf_data_in      = wr0_nib;
`ifdef RF_WRITE_VERIFY_EN
        state_nxt           = S_VA;
`else
        state_nxt           = (op_q == OP_WRP) ? S_WA1 : S_RESP;
`endif
      end
      S_WA1: begin
        bus.rf_write_enable = 1'b1;
        bus.rf_addr         = odd_addr;
        bus.rf_data_in      = data_q[3:0];
`ifdef RF_WRITE_VERIFY_EN
        state_nxt           = S_VA;
`else
        state_nxt           = S_RESP;
`endif
      end
`ifdef RF_WRITE_VERIFY_EN
      S_VA: begin
        bus.rf_select = 1'b1;
        bus.rf_addr   = wsel_q ? odd_addr : wr0_addr;
        state_nxt     = S_VC;
      end
      S_VC: begin
        bus.rf_select = 1'b1;
        state_nxt     = (op_q == OP_WRP && !wsel_q) ? S_WA1 : S_RESP;
      end
`endif
      S_RESP: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response fields are derived from held registers, so they stay stable in RESP.
  always_comb begin
    bus.rsp_data  = 8'd0;
    bus.rsp_carry = 1'b0;
    bus.rsp_zero  = 1'b0;
    if (state == S_RESP) begin
      case (op_q)
        OP_RD, OP_XCH: bus.rsp_data = {4'h0, cap_q};
        OP_RDP:        bus.rsp_data = {even_q, cap_q};
        OP_INC: begin
          bus.rsp_data  = {4'h0, inc_val};
          bus.rsp_carry = (cap_q == 4'hF);
          bus.rsp_zero  = (inc_val == 4'h0);
        end
        default:       bus.rsp_data = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl: behavioural register file, table-driven
// directed vectors, hand-written corner sequences and randomized commands vs a model.
module tb_rf_access_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rf_access_ctrl_if bus();

  rf_access_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Register file: single port, 1-cycle synchronous read, select-gated output.
  logic [3:0] rf_mem [16] = '{default: 4'h0};
  logic [3:0] rf_q;
  always @(posedge clock) begin
    if (bus.rf_write_enable) rf_mem[bus.rf_addr] <= bus.rf_data_in;
    rf_q <= rf_mem[bus.rf_addr];
  end
  assign bus.rf_data_out = bus.rf_select ? rf_q : 4'h0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus monitor: writes never overlap select; bus idle while idle or responding.
  int         bus_err = 0;
  int         we_cnt  = 0;
  logic [3:0] addr_q[$];
  always @(negedge clock) begin
    if (bus.rf_write_enable && bus.rf_select) bus_err++;
    if ((bus.cmd_ready || bus.rsp_valid) && (bus.rf_select || bus.rf_write_enable)) bus_err++;
    if (bus.rf_write_enable) we_cnt++;
    if (bus.rf_select) addr_q.push_back(bus.rf_addr);
  end

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic       err;
    int         lat;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] r;
    logic [7:0] d;
    int         hold;
    logic [7:0] data;
    logic       carry;
    logic       zero;
    int         lat;
  } vec_t;

  logic [3:0] ref_mem [16] = '{default: 4'h0};

  function automatic int exp_lat(input logic [2:0] op);
    int l;
    case (op)
      3'd0: l = 3;
      3'd1: l = 2;
      3'd2: l = 4;
      3'd3: l = 3;
      3'd4: l = 4;
      3'd5: l = 4;
      default: l = 1;
    endcase
`ifdef RF_WRITE_VERIFY_EN
    case (op)
      3'd1, 3'd4, 3'd5: l = l + 2;
      3'd3:             l = l + 4;
      default:          l = l + 0;
    endcase
`endif
    return l;
  endfunction

  function automatic rsp_t model(input logic [2:0] op, input logic [3:0] r, input logic [7:0] d);
    rsp_t       e;
    logic [3:0] ev, od, old, nv;
    e.data = 8'h00; e.carry = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    e.lat  = exp_lat(op);
    ev = {r[3:1], 1'b0};
    od = {r[3:1], 1'b1};
    case (op)
      3'd0: e.data = {4'h0, ref_mem[r]};
      3'd1: ref_mem[r] = d[3:0];
      3'd2: e.data = {ref_mem[ev], ref_mem[od]};
      3'd3: begin ref_mem[ev] = d[7:4]; ref_mem[od] = d[3:0]; end
      3'd4: begin
        old = ref_mem[r];
        nv  = old + 4'h1;
        ref_mem[r] = nv;
        e.data  = {4'h0, nv};
        e.carry = (old == 4'hF);
        e.zero  = (nv == 4'h0);
      end
      3'd5: begin e.data = {4'h0, ref_mem[r]}; ref_mem[r] = d[3:0]; end
      default: e.data = 8'h00;
    endcase
    return e;
  endfunction

  // Called at posedge+1. viol counts busy/hold/return-to-idle protocol violations.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] r, input logic [7:0] d,
                        input int hold, output rsp_t rs, output int viol);
    int n;
    viol = 0;
    rs.data = 8'h00; rs.carry = 1'b0; rs.zero = 1'b0; rs.err = 1'b0; rs.lat = 0;
    bus.cmd_op = op; bus.cmd_reg = r; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 32'(n), 32'd0);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    rs.lat = 1;
    while (bus.rsp_valid !== 1'b1 && rs.lat < 50) begin
      if (bus.cmd_ready !== 1'b0) viol++;
      @(posedge clock); #1; rs.lat++;
    end
    if (rs.lat >= 50) begin
      check("rsp_timeout", 32'(rs.lat), 32'd0);
      return;
    end
    rs.data = bus.rsp_data; rs.carry = bus.rsp_carry;
    rs.zero = bus.rsp_zero; rs.err = bus.rsp_err;
    repeat (hold) begin
      @(posedge clock); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rs.data || bus.rsp_carry !== rs.carry ||
          bus.rsp_zero !== rs.zero || bus.cmd_ready !== 1'b0) viol++;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) viol++;
  endtask

  task automatic check_rsp(input string tag, input rsp_t got, input rsp_t exp, input int viol);
    check({tag, ".data"},  32'(got.data),  32'(exp.data));
    check({tag, ".carry"}, 32'(got.carry), 32'(exp.carry));
    check({tag, ".zero"},  32'(got.zero),  32'(exp.zero));
    check({tag, ".err"},   32'(got.err),   32'(exp.err));
    check({tag, ".lat"},   32'(got.lat),   32'(exp.lat));
    check({tag, ".proto"}, 32'(viol),      32'd0);
  endtask

  vec_t vt[16];

  initial begin
    rsp_t got, exp;
    int   viol, we0;

    vt[0]  = '{3'd1, 4'd5, 8'h0A, 0, 8'h00, 1'b0, 1'b0, 2};
    vt[1]  = '{3'd0, 4'd5, 8'h00, 0, 8'h0A, 1'b0, 1'b0, 3};
    vt[2]  = '{3'd3, 4'd3, 8'h5C, 0, 8'h00, 1'b0, 1'b0, 3};
    vt[3]  = '{3'd2, 4'd2, 8'h00, 0, 8'h5C, 1'b0, 1'b0, 4};
    vt[4]  = '{3'd2, 4'd3, 8'h00, 1, 8'h5C, 1'b0, 1'b0, 4};
    vt[5]  = '{3'd1, 4'd7, 8'h0F, 0, 8'h00, 1'b0, 1'b0, 2};
    vt[6]  = '{3'd4, 4'd7, 8'h00, 2, 8'h00, 1'b1, 1'b1, 4};
    vt[7]  = '{3'd0, 4'd7, 8'h00, 0, 8'h00, 1'b0, 1'b0, 3};
    vt[8]  = '{3'd1, 4'd7, 8'hF3, 0, 8'h00, 1'b0, 1'b0, 2};
    vt[9]  = '{3'd4, 4'd7, 8'h00, 0, 8'h04, 1'b0, 1'b0, 4};
    vt[10] = '{3'd1, 4'd1, 8'h06, 0, 8'h00, 1'b0, 1'b0, 2};
    vt[11] = '{3'd5, 4'd1, 8'h09, 5, 8'h06, 1'b0, 1'b0, 4};
    vt[12] = '{3'd0, 4'd1, 8'h00, 0, 8'h09, 1'b0, 1'b0, 3};
    vt[13] = '{3'd7, 4'd4, 8'hFF, 0, 8'h00, 1'b0, 1'b0, 1};
    vt[14] = '{3'd6, 4'd9, 8'hAA, 3, 8'h00, 1'b0, 1'b0, 1};
    vt[15] = '{3'd0, 4'd2, 8'h00, 0, 8'h05, 1'b0, 1'b0, 3};

    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_reg = 4'd0; bus.cmd_data = 8'd0;
    bus.rsp_ready = 1'b0;

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst.flags",     32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_err}), 32'd0);
    check("rst.rf_bus",    32'({bus.rf_addr, bus.rf_data_in, bus.rf_write_enable, bus.rf_select}), 32'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Reset in the middle of an RDP: outputs drop asynchronously.
    bus.cmd_op = 3'd2; bus.cmd_reg = 4'd2; bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clock); #1;
    check("midrdp.select", 32'(bus.rf_select), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("async.rf_select", 32'(bus.rf_select), 32'd0);
    check("async.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Directed table; the model tracks file contents but the table holds the expectations.
    for (int i = 0; i < 16; i++) begin
      exp = model(vt[i].op, vt[i].r, vt[i].d);
      exp.data = vt[i].data; exp.carry = vt[i].carry; exp.zero = vt[i].zero;
      exp.err  = 1'b0;
      exp.lat  = exp_lat(vt[i].op);
      do_cmd(vt[i].op, vt[i].r, vt[i].d, vt[i].hold, got, viol);
      check_rsp($sformatf("vec%0d", i), got, exp, viol);
      if (exp_lat(vt[i].op) - (vt[i].lat - exp_lat(vt[i].op)) < 0) $display("vector %0d latency note", i);
    end

    // Pair read: addresses 2 then 3 on consecutive cycles, then the capture cycle.
    addr_q.delete();
    exp = model(3'd2, 4'd3, 8'h00);
    do_cmd(3'd2, 4'd3, 8'h00, 0, got, viol);
    check_rsp("pair_rd", got, exp, viol);
    check("pair_rd.sel_cycles", 32'(addr_q.size()), 32'd3);
    if (addr_q.size() >= 2) begin
      check("pair_rd.addr0", 32'(addr_q[0]), 32'd2);
      check("pair_rd.addr1", 32'(addr_q[1]), 32'd3);
    end

    // Reserved op: no file write at all.
    we0 = we_cnt;
    exp = model(3'd7, 4'd7, 8'hFF);
    do_cmd(3'd7, 4'd7, 8'hFF, 0, got, viol);
    check_rsp("reserved", got, exp, viol);
    check("reserved.no_write", 32'(we_cnt - we0), 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      logic [3:0] r;
      logic [7:0] d;
      op = 3'($urandom_range(0, 7));
      r  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      exp = model(op, r, d);
      do_cmd(op, r, d, $urandom_range(0, 3), got, viol);
      check_rsp($sformatf("rand%0d.op%0d", i, op), got, exp, viol);
    end

    check("bus_release", 32'(bus_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
- Sequencer in front of the 16 x 4-bit register file: the file has a single port, a 1-cycle synchronous read and a select-gated 4-bit output.
- Accepts one register-level command at a time from the execute unit and expands it into file accesses: nibble read/write, 8-bit pair read/write, increment (INC/ISZ) and exchange (XCH).
- Returns a single response with data and flags.

Parameters:
- NUM_REGS, 16, register count; the address width is fixed at 4 bits.
- RD_LAT, 1, register file read latency in cycles; only 1 is supported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  3  0=RD, 1=WR, 2=RDP, 3=WRP, 4=INC, 5=XCH, 6..7=reserved.
- cmd_reg  in  4  register index; for RDP/WRP, bit 0 is ignored.
- cmd_data  in  8  write data; WR/XCH use [3:0], WRP uses [7:0].
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  8  result; zero-extended for nibble ops.
- rsp_carry  out  1  INC only: the old value was 4'hF.
- rsp_zero  out  1  INC only: the new value is 4'h0 (ISZ test).
- rsp_err  out  1  write-verify mismatch (see Optional Feature).
- rf_addr  out  4  register file address.
- rf_data_in  out  4  register file write data.
- rf_write_enable  out  1  register file write strobe, one cycle per nibble.
- rf_select  out  1  register file output enable.
- rf_data_out  in  4  register file read data; valid the cycle after its address.

Behaviour:
- Reset: asynchronous and active-high. Forces IDLE.
  - Zero after reset: rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, rf_addr, rf_data_in, rf_write_enable, rf_select.
  - cmd_ready is 1 after reset.
- Reset mid-operation: aborts the command with no response. A WRP may leave only the even nibble written; this is permitted.
- Accept: cmd_valid & cmd_ready at an edge. Op, reg and data are latched. cmd_ready drops the next cycle.
- States: IDLE, RA0, RA1, RC1, WA0, WA1, RESP.
  - RA0/RA1: drive the read address.
  - RC1: capture only.
  - WA0/WA1: write.
- Capture rule: rf_data_out is sampled in the cycle after its address cycle.
- Read cycles: rf_select=1 during every read-address cycle and every capture cycle, and 0 otherwise, so the bus is released.
- Write cycles: rf_write_enable=1 and rf_select=0 during WA states.
- Per-op paths (latency counted from the accept edge to rsp_valid):
  - RD: RA0(r) -> RC1 (capture) -> RESP. rsp_data={4'h0,q}. Latency 3.
  - WR: WA0(r, data[3:0]) -> RESP. Latency 2.
  - RDP: RA0(r&~1) -> RA1(r|1, capture even) -> RC1 (capture odd) -> RESP. rsp_data={even,odd}; the even register is the high nibble. Latency 4.
  - WRP: WA0(r&~1, data[7:4]) -> WA1(r|1, data[3:0]) -> RESP. Latency 3.
  - INC: RA0(r) -> RC1 (capture old) -> WA0(r, old+1 mod 16) -> RESP.
    - rsp_data = new value.
    - rsp_carry = (old==4'hF).
    - rsp_zero = (new==4'h0).
    - Latency 4.
  - XCH: RA0(r) -> RC1 (capture old) -> WA0(r, data[3:0]) -> RESP. rsp_data = old. Latency 4.
  - Reserved ops: go directly to RESP with rsp_data=0 and no file access. Latency 1.
- Flags: rsp_carry and rsp_zero are 0 for all ops except INC.
- RESP: rsp_valid=1 and outputs stable until rsp_ready; then IDLE on the next edge. The earliest next accept is the cycle after.
- Back-to-back: no overlap between commands.
- cmd_valid while busy: ignored, not dropped; the requester must hold it.

Optional Feature:
- Macro: RF_WRITE_VERIFY_EN.
- Defined:
  - Every WA cycle is followed by a read-back address cycle and a capture cycle.
  - A captured value differing from the written nibble sets a sticky rsp_err for that command.
  - Added latency: WR +2, WRP +4, INC +2, XCH +2.
  - rsp_err is cleared when the next command is accepted.
- Undefined: no read-back cycles and rsp_err is tied to 0.

Test Plan:
- Reset test: assert reset mid-RDP. Required: rsp_valid=0 and rf_select=0 immediately (asynchronously). After release: cmd_ready=1 and state IDLE.
- WR/RD test: WR r5=4'hA, then RD r5. Required: rsp_valid at accept+2 for WR and accept+3 for RD; rsp_data=8'h0A.
- Pair test: WRP reg=3, data=8'h5C (writes r2=5, r3=C); then RDP reg=2. Required: rsp_data=8'h5C; rf_addr sequence 2,3 in consecutive cycles.
- INC wrap test: r7=4'hF, INC r7. Required: rsp_data=0, rsp_carry=1, rsp_zero=1, and a later RD r7 returns 0. Then INC on r7=4'h3. Required: rsp_data=4, carry=0, zero=0.
- XCH with backpressure: r1=4'h6, XCH r1 with data=4'h9 and rsp_ready held low for 5 cycles. Required: rsp_data=8'h06 held stable, cmd_ready=0 throughout, and r1 reads 9 afterward.
- Bus-release and reserved-op test: issue op=7. Required: rsp_valid at accept+1, rsp_data=0, rf_write_enable never high. Also check rf_select=0 in every cycle outside read-address and capture cycles.
